// File: rtl/fcmp_arbiter.sv
// Two-requester round-robin arbiter in front of a shared single-precision compare
// (feq/flt/fle) with a one-entry registered result buffer and valid/ready backpressure.
module fcmp_arbiter #(
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_op,
  input  logic [31:0]     req0_x1,
  input  logic [31:0]     req0_x2,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_op,
  input  logic [31:0]     req1_x1,
  input  logic [31:0]     req1_x2,
  input  logic [TAGW-1:0] req1_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_y,
  output logic [TAGW-1:0] out_tag,
  output logic            out_src
);

  // Sign-magnitude compare; NaNs are treated as ordinary bit patterns.
  function automatic logic fcmp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic        s1, s2, bz, res;
    logic [30:0] m1, m2;
    s1  = a[31];
    s2  = b[31];
    m1  = a[30:0];
    m2  = b[30:0];
    bz  = (m1 == 31'd0) && (m2 == 31'd0);
    res = 1'b0;
    case (op)
      2'b00: res = (a == b) || bz;
      2'b01: begin
        case ({s1, s2})
          2'b00:   res = m1 < m2;
          2'b01:   res = 1'b0;
          2'b10:   res = !bz;
          default: res = m1 > m2;
        endcase
      end
      2'b10: begin
        case ({s1, s2})
          2'b00:   res = m1 <= m2;
          2'b01:   res = bz;
          2'b10:   res = 1'b1;
          default: res = m1 >= m2;
        endcase
      end
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic            last_grant;
  logic            res_bit;
  logic            free;
  logic            gnt0, gnt1;
  logic            xfer;
  logic            sel;
  logic [1:0]      sel_op;
  logic [31:0]     sel_x1, sel_x2;
  logic [TAGW-1:0] sel_tag;

  // Buffer may drain and refill in the same cycle.
  assign free = !out_valid || out_ready;

  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_grant);
    gnt1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = free && gnt0;
  assign req1_ready = free && gnt1;
  assign xfer       = req0_ready || req1_ready;
  assign sel        = gnt1;

  always_comb begin
    sel_op  = sel ? req1_op  : req0_op;
    sel_x1  = sel ? req1_x1  : req0_x1;
    sel_x2  = sel ? req1_x2  : req0_x2;
    sel_tag = sel ? req1_tag : req0_tag;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      res_bit    <= 1'b0;
      out_tag    <= '0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      out_valid  <= 1'b1;
      res_bit    <= fcmp(sel_op, sel_x1, sel_x2);
      out_tag    <= sel_tag;
      out_src    <= sel;
      last_grant <= sel;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  assign out_y = {31'd0, res_bit};

endmodule
